// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with a one-entry holding register, valid/read
// handshake and sticky framing/overrun flags.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_IDLE  | line idle, waiting for a falling edge
//  ST_START | timing to mid start bit, then confirm it is still low
//  ST_DATA  | sampling 8 data bits, one per bit period, LSB first
//  ST_STOP  | sampling the stop bit; high loads the byte, low is an error
//  ST_BREAK | stop bit was low; wait for the line to return high
module uart_rx #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       SYS_CLK,
   input  logic       rst_n,
   input  logic       ur_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_rd,
   output logic       rx_busy,
   output logic       frame_err,
   output logic       rx_ovr,
   input  logic       err_clr
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } state_t;

   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

   logic       sync1;
   logic       sync2;
   logic       line_d;
   logic       line;
   logic [1:0] flush;
   logic       armed;
   logic       start_edge;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] cnt;
   logic [2:0]  bit_cnt;
   logic [7:0]  shreg;

   logic reload;
   logic shift_en;
   logic load;
   logic ferr_set;

   assign line    = sync2;
   assign rx_busy = (state != ST_IDLE);

   // Two-flop synchroniser plus a delayed copy for falling-edge detection.
   always_ff @(posedge SYS_CLK or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b1;
         sync2  <= 1'b1;
         line_d <= 1'b1;
      end else begin
         sync1  <= ur_rx;
         sync2  <= sync1;
         line_d <= sync2;
      end
   end

   // The synchroniser resets to 1, so a pin held low through reset would look
   // like a falling edge once flushed. Arm start detection only after the
   // real pin level has been seen high.
   always_ff @(posedge SYS_CLK or negedge rst_n) begin
      if (!rst_n) begin
         flush <= 2'b00;
         armed <= 1'b0;
      end else begin
         flush <= {flush[0], 1'b1};
         if (flush[1] && line) begin
            armed <= 1'b1;
         end
      end
   end

   assign start_edge = armed && line_d && !line;

   // FSM state register.
   always_ff @(posedge SYS_CLK or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-cycle strobes; every transition reloads the timer.
   always_comb begin
      state_nxt = state;
      reload    = 1'b0;
      shift_en  = 1'b0;
      load      = 1'b0;
      ferr_set  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_edge) begin
               state_nxt = ST_START;
               reload    = 1'b1;
            end
         end
         ST_START: begin
            if (cnt == HALF_LAST) begin
               reload    = 1'b1;
               state_nxt = line ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt == BIT_LAST) begin
               reload   = 1'b1;
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) begin
                  state_nxt = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (cnt == BIT_LAST) begin
               reload = 1'b1;
               if (line) begin
                  load      = 1'b1;
                  state_nxt = ST_IDLE;
               end else begin
                  ferr_set  = 1'b1;
                  state_nxt = ST_BREAK;
               end
            end
         end
         ST_BREAK: begin
            if (line) begin
               reload    = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            reload    = 1'b1;
         end
      endcase
   end

   // Bit-period timer; idles at its reload value while waiting for the line.
   always_ff @(posedge SYS_CLK or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 16'd0;
      end else if (reload) begin
         cnt <= 16'd0;
      end else if (state != ST_IDLE && state != ST_BREAK) begin
         cnt <= cnt + 16'd1;
      end
   end

   // Data-bit index and LSB-first shift register.
   always_ff @(posedge SYS_CLK or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= 3'd0;
         shreg   <= 8'h00;
      end else if (state == ST_START) begin
         bit_cnt <= 3'd0;
      end else if (shift_en) begin
         bit_cnt <= bit_cnt + 3'd1;
         shreg   <= {line, shreg[7:1]};
      end
   end

   // Holding register and handshake: a load always wins over a same-cycle read.
   always_ff @(posedge SYS_CLK or negedge rst_n) begin
      if (!rst_n) begin
         rx_data  <= 8'h00;
         rx_valid <= 1'b0;
      end else if (load) begin
         rx_data  <= shreg;
         rx_valid <= 1'b1;
      end else if (rx_rd) begin
         rx_valid <= 1'b0;
      end
   end

   // Sticky error flags: a set in the same cycle as err_clr keeps the flag high.
   always_ff @(posedge SYS_CLK or negedge rst_n) begin
      if (!rst_n) begin
         frame_err <= 1'b0;
         rx_ovr    <= 1'b0;
      end else begin
         if (ferr_set) begin
            frame_err <= 1'b1;
         end else if (err_clr) begin
            frame_err <= 1'b0;
         end
         if (load && rx_valid && !rx_rd) begin
            rx_ovr <= 1'b1;
         end else if (err_clr) begin
            rx_ovr <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a default-rate instance for the main scenarios
// and a CLKS_PER_BIT=4 instance for back-to-back timing.
module tb_uart_rx;

   localparam int CPB   = 434;
   localparam int HB    = CPB / 2;
   localparam int CPB_S = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rx_pin, rx_rd, err_clr;
   logic [7:0] rx_data;
   logic       rx_valid, rx_busy, frame_err, rx_ovr;

   logic       rx_pin_s, rx_rd_s, err_clr_s;
   logic [7:0] rx_data_s;
   logic       rx_valid_s, rx_busy_s, frame_err_s, rx_ovr_s;

   int cyc = 0;
   int n_cmp = 0;
   int n_err = 0;
   int ev_cyc[$];
   logic [7:0] ev_dat[$];

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .SYS_CLK(clk), .rst_n(rst_n), .ur_rx(rx_pin), .rx_data(rx_data),
      .rx_valid(rx_valid), .rx_rd(rx_rd), .rx_busy(rx_busy),
      .frame_err(frame_err), .rx_ovr(rx_ovr), .err_clr(err_clr));

   uart_rx #(.CLKS_PER_BIT(CPB_S)) dut_s (
      .SYS_CLK(clk), .rst_n(rst_n), .ur_rx(rx_pin_s), .rx_data(rx_data_s),
      .rx_valid(rx_valid_s), .rx_rd(rx_rd_s), .rx_busy(rx_busy_s),
      .frame_err(frame_err_s), .rx_ovr(rx_ovr_s), .err_clr(err_clr_s));

   // Consumer for the small instance: log every byte and read it straight away.
   initial begin
      rx_rd_s = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (rx_rd_s) begin
            rx_rd_s = 1'b0;
         end else if (rx_valid_s) begin
            ev_cyc.push_back(cyc);
            ev_dat.push_back(rx_data_s);
            rx_rd_s = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive start + data and the stop level; return one edge before the load edge.
   task automatic send_to_stop(input logic [7:0] b, input logic stop);
      rx_pin = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         rx_pin = b[i];
         repeat (CPB) tick();
      end
      rx_pin = stop;
      repeat (2 + HB) tick();
   endtask

   // Complete the stop bit after the load edge has been ticked.
   task automatic finish_stop();
      repeat (CPB - 3 - HB) tick();
   endtask

   task automatic send_small(input logic [7:0] b);
      rx_pin_s = 1'b0;
      repeat (CPB_S) tick();
      for (int i = 0; i < 8; i++) begin
         rx_pin_s = b[i];
         repeat (CPB_S) tick();
      end
      rx_pin_s = 1'b1;
      repeat (CPB_S) tick();
   endtask

   task automatic test_reset();
      n_cmp++; if (rx_data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
      n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
      n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
      n_cmp++; if ({frame_err, rx_ovr} !== 2'b00) begin n_err++; $display("FAIL reset_flags: got %b want 00", {frame_err, rx_ovr}); end
      n_cmp++; if ({rx_valid_s, rx_busy_s, frame_err_s, rx_ovr_s} !== 4'b0000) begin n_err++; $display("FAIL reset_small: got %b want 0000", {rx_valid_s, rx_busy_s, frame_err_s, rx_ovr_s}); end
   endtask

   task automatic test_single_byte();
      send_to_stop(8'hA5, 1'b1);
      n_cmp++; if ({rx_valid, rx_busy} !== 2'b01) begin n_err++; $display("FAIL single_pre_load: got valid,busy=%b want 01", {rx_valid, rx_busy}); end
      tick();
      n_cmp++; if ({rx_valid, rx_busy} !== 2'b10) begin n_err++; $display("FAIL single_load: got valid,busy=%b want 10", {rx_valid, rx_busy}); end
      n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %h want a5", rx_data); end
      n_cmp++; if ({frame_err, rx_ovr} !== 2'b00) begin n_err++; $display("FAIL single_flags: got %b want 00", {frame_err, rx_ovr}); end
      finish_stop();
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      n_cmp++; if ({rx_valid, rx_data} !== {1'b0, 8'hA5}) begin n_err++; $display("FAIL single_read: got valid=%b data=%h want 0 a5", rx_valid, rx_data); end
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      n_cmp++; if ({rx_valid, rx_data, rx_ovr} !== {1'b0, 8'hA5, 1'b0}) begin n_err++; $display("FAIL idle_read: got valid=%b data=%h ovr=%b want 0 a5 0", rx_valid, rx_data, rx_ovr); end
      repeat (20) tick();
   endtask

   task automatic test_glitch();
      rx_pin = 1'b0;
      tick(); tick();
      n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL busy_at_t0: got %b want 0", rx_busy); end
      tick();
      n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL busy_after_t0: got %b want 1", rx_busy); end
      repeat (97) tick();
      rx_pin = 1'b1;
      repeat (119) tick();
      n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_in_start: got busy=%b want 1", rx_busy); end
      tick();
      n_cmp++; if ({rx_busy, rx_valid, frame_err, rx_ovr} !== 4'b0000) begin n_err++; $display("FAIL glitch_idle: got busy,valid,ferr,ovr=%b want 0000", {rx_busy, rx_valid, frame_err, rx_ovr}); end
      repeat (20) tick();
   endtask

   task automatic test_frame_err();
      send_to_stop(8'h3C, 1'b0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_set_vs_clr: got %b want 1", frame_err); end
      n_cmp++; if ({rx_valid, rx_data} !== {1'b0, 8'hA5}) begin n_err++; $display("FAIL ferr_discard: got valid=%b data=%h want 0 a5", rx_valid, rx_data); end
      repeat (2000) tick();
      n_cmp++; if ({rx_busy, rx_valid} !== 2'b10) begin n_err++; $display("FAIL ferr_break: got busy,valid=%b want 10", {rx_busy, rx_valid}); end
      rx_pin = 1'b1;
      repeat (10) tick();
      n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL ferr_break_exit: got busy=%b want 0", rx_busy); end
      repeat (20) tick();
      send_to_stop(8'h5A, 1'b1);
      tick();
      n_cmp++; if ({rx_valid, rx_data, frame_err} !== {1'b1, 8'h5A, 1'b1}) begin n_err++; $display("FAIL ferr_next_byte: got valid=%b data=%h ferr=%b want 1 5a 1", rx_valid, rx_data, frame_err); end
      finish_stop();
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      n_cmp++; if (frame_err !== 1'b1) begin n_err++; $display("FAIL ferr_sticky: got %b want 1", frame_err); end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL ferr_clear: got %b want 0", frame_err); end
      repeat (20) tick();
   endtask

   task automatic test_overrun();
      send_to_stop(8'h11, 1'b1);
      tick();
      n_cmp++; if ({rx_valid, rx_data, rx_ovr} !== {1'b1, 8'h11, 1'b0}) begin n_err++; $display("FAIL ovr_first: got valid=%b data=%h ovr=%b want 1 11 0", rx_valid, rx_data, rx_ovr); end
      finish_stop();
      send_to_stop(8'h22, 1'b1);
      tick();
      n_cmp++; if ({rx_valid, rx_data, rx_ovr} !== {1'b1, 8'h22, 1'b1}) begin n_err++; $display("FAIL ovr_second: got valid=%b data=%h ovr=%b want 1 22 1", rx_valid, rx_data, rx_ovr); end
      finish_stop();
      send_to_stop(8'h33, 1'b1);
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      n_cmp++; if ({rx_valid, rx_data, rx_ovr} !== {1'b1, 8'h33, 1'b1}) begin n_err++; $display("FAIL ovr_load_rd: got valid=%b data=%h ovr=%b want 1 33 1", rx_valid, rx_data, rx_ovr); end
      finish_stop();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      n_cmp++; if ({frame_err, rx_ovr} !== 2'b00) begin n_err++; $display("FAIL ovr_clear: got ferr,ovr=%b want 00", {frame_err, rx_ovr}); end
      send_to_stop(8'h44, 1'b1);
      rx_rd = 1'b1; tick(); rx_rd = 1'b0;
      n_cmp++; if ({rx_valid, rx_data, rx_ovr} !== {1'b1, 8'h44, 1'b0}) begin n_err++; $display("FAIL load_rd_no_ovr: got valid=%b data=%h ovr=%b want 1 44 0", rx_valid, rx_data, rx_ovr); end
      finish_stop();
      repeat (20) tick();
   endtask

   task automatic test_reset_mid_frame();
      logic busy_seen;
      rx_pin = 1'b0;
      repeat (CPB) tick();
      rx_pin = 1'b1;
      repeat (5 * CPB) tick();
      rst_n = 1'b0;
      rx_pin = 1'b0;
      #1;
      n_cmp++; if ({rx_data, rx_valid, rx_busy, frame_err, rx_ovr} !== 12'h000) begin n_err++; $display("FAIL rst_mid_outputs: got data=%h valid=%b busy=%b ferr=%b ovr=%b want all 0", rx_data, rx_valid, rx_busy, frame_err, rx_ovr); end
      repeat (3) tick();
      rst_n = 1'b1;
      busy_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (rx_busy || rx_valid) busy_seen = 1'b1;
      end
      n_cmp++; if (busy_seen !== 1'b0) begin n_err++; $display("FAIL rst_low_release: got busy/valid seen=%b want 0", busy_seen); end
      rx_pin = 1'b1;
      repeat (10) tick();
      n_cmp++; if ({rx_busy, rx_valid} !== 2'b00) begin n_err++; $display("FAIL rst_no_spurious: got busy,valid=%b want 00", {rx_busy, rx_valid}); end
      send_to_stop(8'h81, 1'b1);
      tick();
      n_cmp++; if ({rx_valid, rx_data, frame_err, rx_ovr} !== {1'b1, 8'h81, 2'b00}) begin n_err++; $display("FAIL rst_next_byte: got valid=%b data=%h ferr=%b ovr=%b want 1 81 0 0", rx_valid, rx_data, frame_err, rx_ovr); end
      finish_stop();
   endtask

   task automatic test_back_to_back();
      int m;
      ev_cyc.delete();
      ev_dat.delete();
      m = cyc;
      send_small(8'h00);
      send_small(8'hFF);
      send_small(8'h55);
      repeat (5) tick();
      n_cmp++; if (ev_cyc.size() != 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", ev_cyc.size()); end
      if (ev_cyc.size() >= 3) begin
         n_cmp++; if (ev_cyc[0] != m + 41) begin n_err++; $display("FAIL b2b_first_cycle: got %0d want %0d", ev_cyc[0] - m, 41); end
         n_cmp++; if ((ev_cyc[1] - ev_cyc[0]) != 40 || (ev_cyc[2] - ev_cyc[1]) != 40) begin n_err++; $display("FAIL b2b_spacing: got %0d,%0d want 40,40", ev_cyc[1] - ev_cyc[0], ev_cyc[2] - ev_cyc[1]); end
         n_cmp++; if ({ev_dat[0], ev_dat[1], ev_dat[2]} !== 24'h00FF55) begin n_err++; $display("FAIL b2b_data: got %h %h %h want 00 ff 55", ev_dat[0], ev_dat[1], ev_dat[2]); end
      end
      n_cmp++; if ({frame_err_s, rx_ovr_s, rx_busy_s} !== 3'b000) begin n_err++; $display("FAIL b2b_flags: got ferr,ovr,busy=%b want 000", {frame_err_s, rx_ovr_s, rx_busy_s}); end
   endtask

   initial begin
      rst_n = 1'b0;
      rx_pin = 1'b1;
      rx_rd = 1'b0;
      err_clr = 1'b0;
      rx_pin_s = 1'b1;
      err_clr_s = 1'b0;
      repeat (3) tick();
      test_reset();
      rst_n = 1'b1;
      repeat (10) tick();
      test_single_byte();
      test_glitch();
      test_frame_err();
      test_overrun();
      test_reset_mid_frame();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
